cache_mem_arbiter: RTL

- Shares the single cacheline-wide physical memory port between the instruction cache (I) and the data cache (D).
- Each cache issues level-held read/write requests for a 128-bit line. The arbiter grants one requester at a time, registers that requester's command, and forwards the memory response back to the granted requester only.
- Sits between the two caches and physical memory in the pipelined core.

---
 rtl/cache_mem_arbiter_if.sv | 40 ++++
 rtl/cache_mem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, physical memory and cache_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both caches plus the memory.
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline-wide memory port between the
// I-cache (read only) and the D-cache (read/writeback).
// Default build: fixed D-over-I priority.
// Define CACHE_MEM_ARBITER_RR_EN for round-robin arbitration on simultaneous
// requests, tracked by a last_grant register that resets to I.
// A winner's command is captured on the edge leaving IDLE. The memory side is
// then driven only from those registers until pmem_resp. Each transaction is
// followed by exactly one IDLE bubble.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic               clk,
  input logic               reset,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t                state;
  logic                  cmd_read;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_WIDTH-1:0] cmd_wdata;

  logic d_req;
  logic i_req;
  logic grant_d;
  logic d_wins_write;

  assign d_req = bus.d_read | bus.d_write;
  assign i_req = bus.i_read;

`ifdef CACHE_MEM_ARBITER_RR_EN
  // last_grant: 0 = I, 1 = D. On a tie the side not granted last time wins.
  logic last_grant;
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  assign grant_d = d_req;
`endif

  // Simultaneous d_read and d_write is treated as a writeback.
  assign d_wins_write = grant_d & bus.d_write;

  // Arbitration FSM: capture the winner's command, then hold it until memory answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
`ifdef CACHE_MEM_ARBITER_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_req | i_req) begin
            state     <= grant_d ? GRANT_D : GRANT_I;
            cmd_read  <= ~d_wins_write;
            cmd_write <= d_wins_write;
            cmd_addr  <= grant_d ? bus.d_address : bus.i_address;
            cmd_wdata <= grant_d ? bus.d_wdata : '0;
`ifdef CACHE_MEM_ARBITER_RR_EN
            last_grant <= grant_d;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.pmem_resp) begin
            state     <= IDLE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side comes straight from the captured command.
  assign bus.pmem_read    = cmd_read;
  assign bus.pmem_write   = cmd_write;
  assign bus.pmem_address = cmd_addr;
  assign bus.pmem_wdata   = cmd_wdata;

  // Completion is routed only to the granted requester. A pmem_resp seen in IDLE is dropped.
  assign bus.i_resp  = (state == GRANT_I) & bus.pmem_resp;
  assign bus.d_resp  = (state == GRANT_D) & bus.pmem_resp;
  assign bus.i_rdata = bus.i_resp ? bus.pmem_rdata : '0;
  assign bus.d_rdata = bus.d_resp ? bus.pmem_rdata : '0;

endmodule
